// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV32I load/store execution with word-wide req/ack memory bus.
//               Optional MISALIGN_TRAP_EN traps misaligned half/word accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base_addr,
    input  logic [31:0] store_data,
    input  logic [31:0] imm,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WB   = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic                 c_timeout_en   = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_W-1:0] c_timeout_last = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    logic [2:0]            r_funct3;
    logic [1:0]            r_off;
    logic [4:0]            r_rd;
    logic [TIMEOUT_W-1:0]  r_tcnt;
    logic                  r_done, r_err, r_mem_req, r_mem_we, r_rf_we;
    logic [31:0]           r_mem_addr, r_mem_wdata, r_rf_wdata;
    logic [3:0]            r_mem_be;
    logic [4:0]            r_rf_waddr;

    logic [31:0] w_ea;
    logic        w_illegal;
    logic        w_misalign;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;

    assign w_ea = base_addr + imm;

    assign w_illegal = is_store ? (funct3[2] || (funct3 == 3'b011))
                                : ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((funct3[1:0] == 2'b01) && w_ea[0]) ||
                        ((funct3[1:0] == 2'b10) && (w_ea[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_st_be    = 4'hF;
        w_st_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                w_st_be    = 4'b0001 << w_ea[1:0];
                w_st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_st_be    = 4'b0011 << {w_ea[1], 1'b0};
                w_st_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane extraction uses the offset latched at launch, not the live inputs.
    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_off)
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            2'd3:    w_byte = mem_rdata[31:24];
            default: ;
        endcase
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_data = {24'd0, w_byte};
            3'b101:  w_ld_data = {16'd0, w_half};
            default: w_ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_rd        <= 5'd0;
            r_tcnt      <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_be    <= 4'd0;
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= 5'd0;
            r_rf_wdata  <= 32'd0;
        end else begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rf_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_funct3 <= funct3;
                        r_off    <= w_ea[1:0];
                        r_rd     <= rd;
                        if (w_illegal || w_misalign) begin
                            r_state <= S_ERR;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state     <= S_REQ;
                            r_tcnt      <= '0;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= is_store;
                            r_mem_addr  <= {w_ea[31:2], 2'b00};
                            r_mem_wdata <= w_st_wdata;
                            r_mem_be    <= is_store ? w_st_be : 4'hF;
                        end
                    end
                end
                S_REQ: begin
                    // An ack in the expiring cycle still completes normally.
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_done    <= 1'b1;
                        if (r_mem_we) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state    <= S_WB;
                            r_rf_we    <= (r_rd != 5'd0);
                            r_rf_waddr <= r_rd;
                            r_rf_wdata <= w_ld_data;
                        end
                    end else if (c_timeout_en && (r_tcnt == c_timeout_last)) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= S_ERR;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + TIMEOUT_W'(1);
                    end
                end
                S_WB:    r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign rf_we     = r_rf_we;
    assign rf_waddr  = r_rf_waddr;
    assign rf_wdata  = r_rf_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, is_store;
    logic [2:0]  funct3;
    logic [31:0] base_addr, store_data, imm;
    logic [4:0]  rd;
    logic        busy, done, err, mem_req, mem_we, mem_ack, rf_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, rf_wdata;
    logic [3:0]  mem_be;
    logic [4:0]  rf_waddr;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .is_store(is_store),
        .funct3(funct3), .base_addr(base_addr), .store_data(store_data),
        .imm(imm), .rd(rd), .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drives start for one cycle; returns at the negedge of the first cycle after launch.
    task automatic launch(input logic st, input logic [2:0] f3, input logic [31:0] b,
                          input logic [31:0] sd, input logic [31:0] im, input logic [4:0] r);
        is_store = st; funct3 = f3; base_addr = b; store_data = sd; imm = im; rd = r;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic ack_cycle(input logic [31:0] d);
        mem_ack = 1'b1; mem_rdata = d;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'd0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        base_addr = 32'd0; store_data = 32'd0; imm = 32'd0; rd = 5'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_rfwe", {31'd0, rf_we}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // LW, ack in first REQ cycle
        launch(1'b0, 3'b010, 32'h1000, 32'd0, 32'd4, 5'd5);
        chk("lw_req", {31'd0, mem_req}, 32'd1);
        chk("lw_busy", {31'd0, busy}, 32'd1);
        chk("lw_addr", mem_addr, 32'h1004);
        ack_cycle(32'hDEADBEEF);
        chk("lw_rfwe", {31'd0, rf_we}, 32'd1);
        chk("lw_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("lw_wdata", rf_wdata, 32'hDEADBEEF);
        chk("lw_done", {31'd0, done}, 32'd1);
        chk("lw_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        chk("lw_done_clr", {31'd0, done}, 32'd0);
        chk("lw_idle", {31'd0, busy}, 32'd0);

        // SB with three wait cycles (ack lands in the last allowed REQ cycle)
        launch(1'b1, 3'b000, 32'h2000, 32'h000000A5, 32'd3, 5'd0);
        chk("sb_be", {28'd0, mem_be}, 32'h8);
        chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("sb_we", {31'd0, mem_we}, 32'd1);
        repeat (3) @(negedge clk);
        chk("sb_wait_req", {31'd0, mem_req}, 32'd1);
        chk("sb_wait_done", {31'd0, done}, 32'd0);
        ack_cycle(32'd0);
        chk("sb_done", {31'd0, done}, 32'd1);
        chk("sb_err", {31'd0, err}, 32'd0);
        chk("sb_rfwe", {31'd0, rf_we}, 32'd0);
        chk("sb_req_drop", {31'd0, mem_req}, 32'd0);
        @(negedge clk);

        // SH upper half, SW
        launch(1'b1, 3'b001, 32'h4000, 32'h1234BEEF, 32'd2, 5'd0);
        chk("sh_be", {28'd0, mem_be}, 32'hC);
        chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
        ack_cycle(32'd0);
        @(negedge clk);
        launch(1'b1, 3'b010, 32'h4000, 32'h1234BEEF, 32'd8, 5'd0);
        chk("sw_be", {28'd0, mem_be}, 32'hF);
        chk("sw_addr", mem_addr, 32'h4008);
        ack_cycle(32'd0);
        @(negedge clk);

        // Byte/half load extension
        launch(1'b0, 3'b000, 32'h3000, 32'd0, 32'd2, 5'd7);
        ack_cycle(32'h00800000);
        chk("lb_sext", rf_wdata, 32'hFFFFFF80);
        @(negedge clk);
        launch(1'b0, 3'b100, 32'h3000, 32'd0, 32'd2, 5'd7);
        ack_cycle(32'h00800000);
        chk("lbu_zext", rf_wdata, 32'h00000080);
        @(negedge clk);
        launch(1'b0, 3'b001, 32'h3000, 32'd0, 32'd2, 5'd3);
        ack_cycle(32'h87651234);
        chk("lh_sext", rf_wdata, 32'hFFFF8765);
        @(negedge clk);
        launch(1'b0, 3'b101, 32'h3000, 32'd0, 32'd0, 5'd3);
        ack_cycle(32'h87659234);
        chk("lhu_zext", rf_wdata, 32'h00009234);
        @(negedge clk);
        launch(1'b0, 3'b001, 32'h3000, 32'd0, 32'd0, 5'd0);
        ack_cycle(32'h12348765);
        chk("lh_rd0_rfwe", {31'd0, rf_we}, 32'd0);
        chk("lh_rd0_done", {31'd0, done}, 32'd1);
        @(negedge clk);

        // Timeout: four REQ cycles without ack
        launch(1'b0, 3'b010, 32'h5000, 32'd0, 32'd0, 5'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_req%0d", i), {31'd0, mem_req}, 32'd1);
            @(negedge clk);
        end
        chk("to_req_drop", {31'd0, mem_req}, 32'd0);
        chk("to_done", {31'd0, done}, 32'd1);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_rfwe", {31'd0, rf_we}, 32'd0);
        @(negedge clk);
        chk("to_idle", {31'd0, busy}, 32'd0);

        // Illegal funct3 (load and store)
        launch(1'b0, 3'b011, 32'h6000, 32'd0, 32'd0, 5'd1);
        chk("ill_ld_req", {31'd0, mem_req}, 32'd0);
        chk("ill_ld_err", {30'd0, done, err}, 32'd3);
        @(negedge clk);
        launch(1'b1, 3'b100, 32'h6000, 32'd0, 32'd0, 5'd1);
        chk("ill_st_req", {31'd0, mem_req}, 32'd0);
        chk("ill_st_err", {30'd0, done, err}, 32'd3);
        @(negedge clk);

        // Misaligned word
        launch(1'b0, 3'b010, 32'h1000, 32'd0, 32'd2, 5'd4);
`ifdef MISALIGN_TRAP_EN
        chk("mis_req", {31'd0, mem_req}, 32'd0);
        chk("mis_err", {30'd0, done, err}, 32'd3);
        @(negedge clk);
`else
        chk("mis_addr", mem_addr, 32'h1000);
        ack_cycle(32'h0BADF00D);
        chk("mis_err", {30'd0, done, err}, 32'd2);
        chk("mis_wdata", rf_wdata, 32'h0BADF00D);
        @(negedge clk);
`endif

        // start while busy is ignored
        launch(1'b0, 3'b010, 32'h7000, 32'd0, 32'd0, 5'd9);
        is_store = 1'b1; base_addr = 32'h9000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_addr", mem_addr, 32'h7000);
        chk("busy_we", {31'd0, mem_we}, 32'd0);
        ack_cycle(32'h55AA55AA);
        chk("busy_wdata", rf_wdata, 32'h55AA55AA);
        @(negedge clk);

        // Async reset mid-REQ
        launch(1'b0, 3'b010, 32'h8000, 32'd0, 32'd0, 5'd2);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, mem_req}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("arst_stay_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
